// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter: per-core pending slots, address-dependent latency, one RAM access at a time.
// Optional counters stat_grants/stat_busy_cycles/stat_dropped are built when MEM_ARB_STATS_EN is defined.
module mem_read_arbiter #(
  parameter int NCORES   = 16,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int SLOW_LAT = 10,
  parameter int FAST_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req_valid,
  input  logic [NCORES*AW-1:0] req_addr,
  output logic [NCORES-1:0]    resp_ready,
  output logic [DW-1:0]        resp_data,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_rd_addr,
  input  logic [DW-1:0]        mem_rd_data,
  output logic                 busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]          stat_grants,
  output logic [31:0]          stat_busy_cycles,
  output logic [31:0]          stat_dropped
`endif
);

  localparam int IDW    = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int MAXLAT = (SLOW_LAT > FAST_LAT) ? SLOW_LAT : FAST_LAT;
  localparam int TW     = $clog2(MAXLAT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]        state;
  logic [NCORES-1:0] pending;
  logic [AW-1:0]     addr_q [NCORES];
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    cur_id;
  logic [TW-1:0]     lat_q;
  logic [TW-1:0]     timer;
  logic [AW-1:0]     rd_addr_q;

  logic              gnt_any;
  logic [IDW-1:0]    gnt_id;
  logic [IDW-1:0]    cand;
  logic              grant;
  logic              busy_int;
  logic              at_resp;
  logic [NCORES-1:0] take;

  // Walk offsets from highest to lowest so the smallest offset from rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      cand = IDW'((int'(rr_ptr) + i) % NCORES);
      if (pending[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign grant    = (state == ST_IDLE) && gnt_any;
  assign busy_int = (state == ST_WAIT) || grant;
  assign at_resp  = (state == ST_WAIT) && (timer == lat_q);

  // The slot being granted this cycle is free for a new pulse from the same core.
  always_comb begin
    take = '0;
    for (int k = 0; k < NCORES; k++)
      take[k] = req_valid[k] & (~pending[k] | (grant & (gnt_id == IDW'(k))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pending   <= '0;
      rr_ptr    <= '0;
      cur_id    <= '0;
      lat_q     <= '0;
      timer     <= '0;
      rd_addr_q <= '0;
      for (int k = 0; k < NCORES; k++) addr_q[k] <= '0;
    end else begin
      if (grant) begin
        state     <= ST_WAIT;
        cur_id    <= gnt_id;
        rd_addr_q <= addr_q[gnt_id];
        lat_q     <= addr_q[gnt_id][AW-1] ? TW'(FAST_LAT) : TW'(SLOW_LAT);
        timer     <= TW'(1);
        rr_ptr    <= (gnt_id == IDW'(NCORES - 1)) ? '0 : gnt_id + 1'b1;
      end else if (state == ST_WAIT) begin
        if (timer == lat_q) begin
          state <= ST_IDLE;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
      for (int k = 0; k < NCORES; k++) begin
        if (take[k]) begin
          pending[k] <= 1'b1;
          addr_q[k]  <= req_addr[k*AW +: AW];
        end else if (grant && (gnt_id == IDW'(k))) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  assign busy        = busy_int & ~rst;
  assign mem_rd_en   = (state == ST_WAIT) && (timer == lat_q - 1'b1) && !rst;
  assign mem_rd_addr = rst ? '0 : rd_addr_q;
  assign resp_ready  = (at_resp && !rst) ? (NCORES'(1) << cur_id) : '0;
  assign resp_data   = (at_resp && !rst) ? mem_rd_data : '0;

`ifdef MEM_ARB_STATS_EN
  localparam int CW = IDW + 1;
  logic [CW-1:0] drop_cnt;
  logic [32:0]   drop_sum;

  always_comb begin
    drop_cnt = '0;
    for (int k = 0; k < NCORES; k++)
      drop_cnt = drop_cnt + CW'(req_valid[k] & ~take[k]);
  end

  assign drop_sum = {1'b0, stat_dropped} + 33'(drop_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants      <= '0;
      stat_busy_cycles <= '0;
      stat_dropped     <= '0;
    end else begin
      if (grant && (stat_grants != '1))         stat_grants      <= stat_grants + 1'b1;
      if (busy_int && (stat_busy_cycles != '1)) stat_busy_cycles <= stat_busy_cycles + 1'b1;
      stat_dropped <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end
`endif

endmodule
